// File: rtl/btb_update_ctrl.sv
// BTB update scheduler: filters not-taken results, arbitrates EX/ID round-robin, queues
// accepted updates in a DEPTH-entry FIFO. Optional macro: BTB_UPD_COALESCE_EN.
module btb_update_ctrl #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    ex_valid_i,
    input  logic [63:0]             ex_pc_i,
    input  logic [63:0]             ex_target_i,
    input  logic                    ex_taken_i,
    input  logic [1:0]              ex_type_i,
    output logic                    ex_ready_o,

    input  logic                    id_valid_i,
    input  logic [63:0]             id_pc_i,
    input  logic [63:0]             id_target_i,
    input  logic                    id_taken_i,
    input  logic [1:0]              id_type_i,
    output logic                    id_ready_o,

    input  logic                    suspend_i,

    output logic                    update_en_o,
    output logic [63:0]             pc_u_o,
    output logic [63:0]             target_u_o,
    output logic                    taken_u_o,
    output logic [1:0]              type_u_o,
    output logic [$clog2(DEPTH):0]  depth_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] target;
        logic [1:0]  btype;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            prio_q, prio_d;

    logic            ex_live, ex_dead;
    logic            id_live, id_dead;
    logic            can_enq;
    logic            ex_grant, id_grant, any_grant;
    logic            dup;
    logic            push, pop;
    logic            out_vld;
    entry_t          sel_entry;
    entry_t          head_entry;

    // Request classification; dead requests bypass arbitration entirely.
    always_comb begin
        ex_live = ex_valid_i & ex_taken_i;
        ex_dead = ex_valid_i & ~ex_taken_i;
        id_live = id_valid_i & id_taken_i;
        id_dead = id_valid_i & ~id_taken_i;
    end

    // Registered occupancy only: a same-cycle issue never frees a slot for enqueue.
    assign can_enq = (count_q < FULL) & ~reset;

    always_comb begin
        ex_grant  = can_enq & ex_live & (~id_live | ~prio_q);
        id_grant  = can_enq & id_live & (~ex_live | prio_q);
        any_grant = ex_grant | id_grant;
    end

    assign ex_ready_o = ex_dead | ex_grant;
    assign id_ready_o = id_dead | id_grant;

    always_comb begin
        sel_entry = '0;
        if (ex_grant) begin
            sel_entry.pc     = ex_pc_i;
            sel_entry.target = ex_target_i;
            sel_entry.btype  = ex_type_i;
        end else begin
            sel_entry.pc     = id_pc_i;
            sel_entry.target = id_target_i;
            sel_entry.btype  = id_type_i;
        end
    end

`ifdef BTB_UPD_COALESCE_EN
    entry_t last_q, last_d;
    logic   last_vld_q, last_vld_d;

    assign dup = last_vld_q & (sel_entry == last_q);

    // Copy is invalidated once the queue drains, so a repeat after drain is re-queued.
    always_comb begin
        last_d     = last_q;
        last_vld_d = last_vld_q;
        if (push) begin
            last_d     = sel_entry;
            last_vld_d = 1'b1;
        end else if (pop && (count_q == CW'(1))) begin
            last_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else begin
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
        end
    end
`else
    assign dup = 1'b0;
`endif

    assign push = any_grant & ~dup;

    // Issue side
    assign head_entry  = mem_q[head_q];
    assign out_vld     = (count_q != '0) & ~reset;
    assign update_en_o = out_vld & ~suspend_i;
    assign pop         = update_en_o;
    assign taken_u_o   = update_en_o;
    assign pc_u_o      = out_vld ? head_entry.pc     : 64'h0;
    assign target_u_o  = out_vld ? head_entry.target : 64'h0;
    assign type_u_o    = out_vld ? head_entry.btype  : 2'b00;
    assign depth_o     = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        prio_d  = prio_q;
        if (push) begin
            tail_d = tail_q + PW'(1);
        end
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Pointer moves to the loser; coalesced grants still rotate it.
        if (any_grant) begin
            prio_d = ex_grant;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            prio_q  <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            prio_q  <= prio_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= sel_entry;
        end
    end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed table-driven bench for btb_update_ctrl (DEPTH=4), plus coalesce/drain sequence.
module tb_btb_update_ctrl;

    logic        clk;
    logic        reset;
    logic        ex_valid_i, ex_taken_i, id_valid_i, id_taken_i, suspend_i;
    logic [63:0] ex_pc_i, ex_target_i, id_pc_i, id_target_i;
    logic [1:0]  ex_type_i, id_type_i;
    logic        ex_ready_o, id_ready_o, update_en_o, taken_u_o;
    logic [63:0] pc_u_o, target_u_o;
    logic [1:0]  type_u_o;
    logic [2:0]  depth_o;

    int checks = 0;
    int errors = 0;

`ifdef BTB_UPD_COALESCE_EN
    localparam int EXP_CO = 1;
`else
    localparam int EXP_CO = 2;
`endif

    btb_update_ctrl #(.DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .ex_valid_i  (ex_valid_i),
        .ex_pc_i     (ex_pc_i),
        .ex_target_i (ex_target_i),
        .ex_taken_i  (ex_taken_i),
        .ex_type_i   (ex_type_i),
        .ex_ready_o  (ex_ready_o),
        .id_valid_i  (id_valid_i),
        .id_pc_i     (id_pc_i),
        .id_target_i (id_target_i),
        .id_taken_i  (id_taken_i),
        .id_type_i   (id_type_i),
        .id_ready_o  (id_ready_o),
        .suspend_i   (suspend_i),
        .update_en_o (update_en_o),
        .pc_u_o      (pc_u_o),
        .target_u_o  (target_u_o),
        .taken_u_o   (taken_u_o),
        .type_u_o    (type_u_o),
        .depth_o     (depth_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, sus;
        logic        exv, ext;
        logic [63:0] expc, extg;
        logic [1:0]  exty;
        logic        idv, idt;
        logic [63:0] idpc, idtg;
        logic [1:0]  idty;
        logic        exr, idr, en;
        logic [63:0] pc, tg;
        logic [1:0]  ty;
        logic        tk;
        logic [2:0]  dep;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rst, input logic sus,
        input logic exv, input logic ext, input logic [63:0] expc, input logic [63:0] extg,
        input logic [1:0] exty,
        input logic idv, input logic idt, input logic [63:0] idpc, input logic [63:0] idtg,
        input logic [1:0] idty,
        input logic exr, input logic idr, input logic en, input logic [63:0] pc,
        input logic [63:0] tg, input logic [1:0] ty, input logic tk, input logic [2:0] dep);
        vec_t v;
        v.rst = rst; v.sus = sus;
        v.exv = exv; v.ext = ext; v.expc = expc; v.extg = extg; v.exty = exty;
        v.idv = idv; v.idt = idt; v.idpc = idpc; v.idtg = idtg; v.idty = idty;
        v.exr = exr; v.idr = idr; v.en = en; v.pc = pc; v.tg = tg; v.ty = ty;
        v.tk = tk; v.dep = dep;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset       = v.rst;
        suspend_i   = v.sus;
        ex_valid_i  = v.exv; ex_taken_i = v.ext; ex_pc_i = v.expc;
        ex_target_i = v.extg; ex_type_i = v.exty;
        id_valid_i  = v.idv; id_taken_i = v.idt; id_pc_i = v.idpc;
        id_target_i = v.idtg; id_type_i = v.idty;
    endtask

    task automatic check_vec(input vec_t v, input int idx);
        chk("ex_ready",  idx, 64'(ex_ready_o),  64'(v.exr));
        chk("id_ready",  idx, 64'(id_ready_o),  64'(v.idr));
        chk("update_en", idx, 64'(update_en_o), 64'(v.en));
        chk("pc_u",      idx, pc_u_o,           v.pc);
        chk("target_u",  idx, target_u_o,       v.tg);
        chk("type_u",    idx, 64'(type_u_o),    64'(v.ty));
        chk("taken_u",   idx, 64'(taken_u_o),   64'(v.tk));
        chk("depth",     idx, 64'(depth_o),     64'(v.dep));
    endtask

    vec_t idle;

    initial begin
        clk = 1'b0;
        idle = mk(0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0,0);
        drive(idle);
        reset = 1'b1;

        //          rst sus ex:v t pc       tgt      ty id:v t pc     tgt    ty  exr idr en pc       tgt      ty tk dep
        tbl.push_back(mk(1,0, 0,0,64'h0,   64'h0,   0, 1,0,64'h0, 64'h0, 0,  0,1,0,64'h0,   64'h0,   0,0,0));
        tbl.push_back(mk(0,0, 1,1,64'h1000,64'h2000,1, 0,0,64'h0, 64'h0, 0,  1,0,0,64'h0,   64'h0,   0,0,0));
        tbl.push_back(mk(0,0, 0,0,64'h0,   64'h0,   0, 0,0,64'h0, 64'h0, 0,  0,0,1,64'h1000,64'h2000,1,1,1));
        tbl.push_back(mk(0,0, 0,0,64'h0,   64'h0,   0, 0,0,64'h0, 64'h0, 0,  0,0,0,64'h0,   64'h0,   0,0,0));
        tbl.push_back(mk(1,0, 0,0,64'h0,   64'h0,   0, 0,0,64'h0, 64'h0, 0,  0,0,0,64'h0,   64'h0,   0,0,0));
        // Both live under suspend: grants alternate EX, ID, EX, ID, then full
        tbl.push_back(mk(0,1, 1,1,64'h10,  64'h110, 2, 1,1,64'h20,64'h120,3, 1,0,0,64'h0,   64'h0,   0,0,0));
        tbl.push_back(mk(0,1, 1,1,64'h10,  64'h110, 2, 1,1,64'h20,64'h120,3, 0,1,0,64'h10,  64'h110, 2,0,1));
        tbl.push_back(mk(0,1, 1,1,64'h10,  64'h110, 2, 1,1,64'h20,64'h120,3, 1,0,0,64'h10,  64'h110, 2,0,2));
        tbl.push_back(mk(0,1, 1,1,64'h10,  64'h110, 2, 1,1,64'h20,64'h120,3, 0,1,0,64'h10,  64'h110, 2,0,3));
        tbl.push_back(mk(0,1, 1,1,64'h10,  64'h110, 2, 1,1,64'h20,64'h120,3, 0,0,0,64'h10,  64'h110, 2,0,4));
        // Dead ID while full
        tbl.push_back(mk(0,1, 0,0,64'h0,   64'h0,   0, 1,0,64'h20,64'h120,3, 0,1,0,64'h10,  64'h110, 2,0,4));
        // Full and issuing: EX refused, accepted next cycle; tail wraps
        tbl.push_back(mk(0,0, 1,1,64'h30,  64'h130, 1, 0,0,64'h0, 64'h0, 0,  0,0,1,64'h10,  64'h110, 2,1,4));
        tbl.push_back(mk(0,0, 1,1,64'h30,  64'h130, 1, 0,0,64'h0, 64'h0, 0,  1,0,1,64'h20,  64'h120, 3,1,3));
        tbl.push_back(mk(0,0, 0,0,64'h0,   64'h0,   0, 0,0,64'h0, 64'h0, 0,  0,0,1,64'h10,  64'h110, 2,1,3));
        tbl.push_back(mk(0,0, 0,0,64'h0,   64'h0,   0, 0,0,64'h0, 64'h0, 0,  0,0,1,64'h20,  64'h120, 3,1,2));
        tbl.push_back(mk(0,0, 0,0,64'h0,   64'h0,   0, 0,0,64'h0, 64'h0, 0,  0,0,1,64'h30,  64'h130, 1,1,1));
        tbl.push_back(mk(0,0, 0,0,64'h0,   64'h0,   0, 0,0,64'h0, 64'h0, 0,  0,0,0,64'h0,   64'h0,   0,0,0));
        // Fill to 3 under suspend, then reset mid-operation with a live request
        tbl.push_back(mk(0,1, 1,1,64'h50,  64'h150, 0, 0,0,64'h0, 64'h0, 0,  1,0,0,64'h0,   64'h0,   0,0,0));
        tbl.push_back(mk(0,1, 1,1,64'h60,  64'h160, 0, 0,0,64'h0, 64'h0, 0,  1,0,0,64'h50,  64'h150, 0,0,1));
        tbl.push_back(mk(0,1, 1,1,64'h70,  64'h170, 0, 0,0,64'h0, 64'h0, 0,  1,0,0,64'h50,  64'h150, 0,0,2));
        tbl.push_back(mk(1,1, 1,1,64'h80,  64'h180, 0, 0,0,64'h0, 64'h0, 0,  0,0,0,64'h0,   64'h0,   0,0,3));
        tbl.push_back(mk(0,0, 0,0,64'h0,   64'h0,   0, 0,0,64'h0, 64'h0, 0,  0,0,0,64'h0,   64'h0,   0,0,0));

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            check_vec(tbl[i], i);
        end

        // Identical EX request twice back-to-back under suspend
        @(negedge clk);
        drive(mk(0,1, 1,1,64'h40,64'h140,1, 0,0,64'h0,64'h0,0, 0,0,0,0,0,0,0,0));
        #1;
        chk("co_ready1", 100, 64'(ex_ready_o), 64'd1);
        @(negedge clk);
        #1;
        chk("co_ready2", 101, 64'(ex_ready_o), 64'd1);
        chk("co_depth1", 101, 64'(depth_o), 64'd1);
        @(negedge clk);
        drive(idle);
        suspend_i = 1'b1;
        #1;
        chk("co_depth2", 102, 64'(depth_o), 64'(EXP_CO));
        @(negedge clk);
        suspend_i = 1'b0;
        #1;
        chk("co_issue_en", 103, 64'(update_en_o), 64'd1);
        chk("co_issue_pc", 103, pc_u_o, 64'h40);

        // Bounded drain
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            #1;
            if (depth_o == 3'd0) break;
        end
        chk("drain_depth", 104, 64'(depth_o), 64'd0);
        chk("drain_en",    104, 64'(update_en_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
